// File: rtl/local_pkt_shifter.sv
// rtl/local_pkt_shifter.sv - pops one readout word per packet and shifts {start, ID, word} out serially
module local_pkt_shifter #(
  parameter int unsigned WORD_BITS = 54,
  parameter int unsigned ID_BITS   = 5,
  parameter int unsigned GAP_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic [ID_BITS-1:0]   ID,
  input  logic [WORD_BITS-1:0] fifoDout,
  input  logic                 fifoEmpty,
  output logic                 fifoRE,
  output logic                 freezeRE,
  input  logic                 xoffIn,
  output logic                 datOut,
  output logic                 busy,
  output logic                 pktSent,
  output logic [15:0]          sentCount
);

  localparam int unsigned PKT_BITS = 1 + ID_BITS + WORD_BITS;
  localparam int unsigned REM_BITS = ID_BITS + WORD_BITS;
  localparam int unsigned CNT_W    = $clog2(PKT_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_xoff_meta;
  logic                r_xoff_s;
  // Holds the bits still to be sent after the one currently on datOut.
  logic [REM_BITS-1:0] r_shreg;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_fifo_re;
  logic                r_freeze;
  logic                r_dat;
  logic                r_busy;
  logic                r_pkt_sent;
  logic [15:0]         r_sent_count;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_xoff_meta <= 1'b0;
      r_xoff_s    <= 1'b0;
    end else begin
      r_xoff_meta <= xoffIn;
      r_xoff_s    <= r_xoff_meta;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!fifoEmpty && !r_xoff_s) w_next = S_LOAD;
      S_LOAD:  w_next = S_SHIFT;
      S_SHIFT: if (r_cnt == '0) w_next = S_GAP;
      S_GAP:   if (r_cnt == '0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_shreg      <= '0;
      r_cnt        <= '0;
      r_fifo_re    <= 1'b0;
      r_freeze     <= 1'b0;
      r_dat        <= 1'b0;
      r_busy       <= 1'b0;
      r_pkt_sent   <= 1'b0;
      r_sent_count <= '0;
    end else begin
      r_fifo_re  <= (w_next == S_LOAD);
      r_freeze   <= (w_next == S_LOAD) || (w_next == S_SHIFT);
      r_busy     <= (w_next != S_IDLE);
      r_pkt_sent <= (r_state == S_SHIFT) && (w_next == S_GAP);
      case (r_state)
        S_LOAD: begin
          r_dat   <= 1'b1;
          r_shreg <= {ID, fifoDout};
          r_cnt   <= CNT_W'(PKT_BITS - 1);
        end
        S_SHIFT: begin
          r_shreg <= {r_shreg[REM_BITS-2:0], 1'b0};
          if (r_cnt == '0) begin
            r_dat        <= 1'b0;
            r_cnt        <= CNT_W'(GAP_BITS - 1);
            r_sent_count <= r_sent_count + 16'd1;
          end else begin
            r_dat <= r_shreg[REM_BITS-1];
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_GAP: begin
          r_dat <= 1'b0;
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        default: r_dat <= 1'b0;
      endcase
    end
  end

  assign fifoRE    = r_fifo_re;
  assign freezeRE  = r_freeze;
  assign datOut    = r_dat;
  assign busy      = r_busy;
  assign pktSent   = r_pkt_sent;
  assign sentCount = r_sent_count;

endmodule
